// File: rtl/branch_cond_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : branch_cond_unit_pkg
// Brief    : Condition codes and FSM state encoding for the branch condition unit.
// Revision : 1.0
// ============================================================================
package branch_cond_unit_pkg;

  localparam logic [2:0] COND_EQZ = 3'd0;
  localparam logic [2:0] COND_NEZ = 3'd1;
  localparam logic [2:0] COND_GEZ = 3'd2;
  localparam logic [2:0] COND_LTZ = 3'd3;
  localparam logic [2:0] COND_GTZ = 3'd4;
  localparam logic [2:0] COND_LEZ = 3'd5;
  localparam logic [2:0] COND_EQA = 3'd6;
  localparam logic [2:0] COND_LTA = 3'd7;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EVAL = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

endpackage
`default_nettype wire

// File: rtl/branch_cond_unit_cond_eval.sv
`default_nettype none
// ============================================================================
// Module   : cond_eval
// Brief    : Combinational branch-condition comparator (shared with ALU flags).
// Revision : 1.0
// ============================================================================
module cond_eval
  import branch_cond_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [2:0]            cond,
  output logic                  result
);

  logic w_zero;
  logic w_neg;

  assign w_zero = (b == '0);
  assign w_neg  = b[DATA_WIDTH-1];

  always_comb begin
    result = 1'b0;
    case (cond)
      COND_EQZ: result = w_zero;
      COND_NEZ: result = !w_zero;
      COND_GEZ: result = !w_neg;
      COND_LTZ: result = w_neg;
      COND_GTZ: result = !w_neg && !w_zero;
      COND_LEZ: result = w_neg || w_zero;
      COND_EQA: result = (b == a);
      COND_LTA: result = ($signed(b) < $signed(a));
      default:  result = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/branch_cond_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_cond_unit
// Brief    : Branch condition evaluation with valid/ack hold, overrun flag and
//            saturating evaluation/taken counters.
// Revision : 1.0
// ============================================================================
module branch_cond_unit
  import branch_cond_unit_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int CNT_WIDTH   = 16,
  parameter int REG_INPUT   = 0,
  parameter int LEGACY_MODE = 0
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  con_in,
  input  logic                  opa_in,
  input  logic [2:0]            ir_cond,
  input  logic [DATA_WIDTH-1:0] bus_mux_out,
  input  logic                  q_ack,
  input  logic                  cnt_clr,
  output logic                  q,
  output logic                  q_valid,
  output logic                  busy,
  output logic                  overrun,
  output logic [CNT_WIDTH-1:0]  eval_cnt,
  output logic [CNT_WIDTH-1:0]  taken_cnt
);

  localparam logic [CNT_WIDTH-1:0] c_cnt_one      = CNT_WIDTH'(1);
  localparam logic [1:0]           c_accept_state = (REG_INPUT != 0) ? EVAL : HOLD;

  logic [1:0]            r_state;
  logic [1:0]            w_next_state;
  logic [DATA_WIDTH-1:0] r_opa;
  logic [DATA_WIDTH-1:0] w_eval_b;
  logic [DATA_WIDTH-1:0] w_eval_a;
  logic [2:0]            w_cond_in;
  logic [2:0]            w_eval_cond;
  logic                  w_result;
  logic                  w_accept;
  logic                  w_register;
  logic                  w_overrun_set;
  logic                  r_q;
  logic                  r_overrun;
  logic [CNT_WIDTH-1:0]  r_eval_cnt;
  logic [CNT_WIDTH-1:0]  r_taken_cnt;

  generate
    if (LEGACY_MODE != 0) begin : g_legacy
      logic w_unused_cond;
      assign w_unused_cond = ir_cond[2];
      assign w_cond_in     = {1'b0, ir_cond[1:0]};
    end else begin : g_full
      assign w_cond_in = ir_cond;
    end
  endgenerate

  assign w_accept      = con_in && ((r_state == IDLE) || ((r_state == HOLD) && q_ack));
  assign w_overrun_set = con_in && (r_state == HOLD) && !q_ack;

  // Operand A is captured alongside B so a coincident opa_in never leaks in.
  generate
    if (REG_INPUT != 0) begin : g_reg_input
      logic [DATA_WIDTH-1:0] r_b;
      logic [DATA_WIDTH-1:0] r_a;
      logic [2:0]            r_cond;
      always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
          r_b    <= '0;
          r_a    <= '0;
          r_cond <= '0;
        end else if (w_accept) begin
          r_b    <= bus_mux_out;
          r_a    <= r_opa;
          r_cond <= w_cond_in;
        end
      end
      assign w_eval_b    = r_b;
      assign w_eval_a    = r_a;
      assign w_eval_cond = r_cond;
      assign w_register  = (r_state == EVAL);
    end else begin : g_direct
      assign w_eval_b    = bus_mux_out;
      assign w_eval_a    = r_opa;
      assign w_eval_cond = w_cond_in;
      assign w_register  = w_accept;
    end
  endgenerate

  cond_eval #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_cond_eval (
    .b      (w_eval_b),
    .a      (w_eval_a),
    .cond   (w_eval_cond),
    .result (w_result)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) r_state <= IDLE;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (con_in) w_next_state = c_accept_state;
      EVAL:    w_next_state = HOLD;
      HOLD:    if (q_ack) w_next_state = con_in ? c_accept_state : IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    busy    = (r_state == EVAL);
    q_valid = (r_state == HOLD);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_opa       <= '0;
      r_q         <= 1'b0;
      r_overrun   <= 1'b0;
      r_eval_cnt  <= '0;
      r_taken_cnt <= '0;
    end else begin
      if (opa_in)        r_opa     <= bus_mux_out;
      if (w_register)    r_q       <= w_result;
      if (w_overrun_set) r_overrun <= 1'b1;
      if (cnt_clr) begin
        r_eval_cnt  <= '0;
        r_taken_cnt <= '0;
      end else if (w_register) begin
        if (r_eval_cnt != '1)              r_eval_cnt  <= r_eval_cnt + c_cnt_one;
        if (w_result && r_taken_cnt != '1) r_taken_cnt <= r_taken_cnt + c_cnt_one;
      end
    end
  end

  assign q         = r_q;
  assign overrun   = r_overrun;
  assign eval_cnt  = r_eval_cnt;
  assign taken_cnt = r_taken_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_cond_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_cond_unit
// Brief    : Directed scoreboard bench over direct, registered and legacy builds.
// Revision : 1.0
// ============================================================================
module tb_branch_cond_unit;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        con_in = 1'b0;
  logic        opa_in = 1'b0;
  logic [2:0]  ir_cond = 3'd0;
  logic [31:0] bus = 32'd0;
  logic        q_ack = 1'b0;
  logic        cnt_clr = 1'b0;

  logic        q0, qv0, busy0, ov0;
  logic [3:0]  ec0, tc0;
  logic        q1, qv1, busy1, ov1;
  logic [15:0] ec1, tc1;
  logic        q2, qv2, busy2, ov2;
  logic [15:0] ec2, tc2;

  int checks = 0;
  int errors = 0;
  bit exp_q[$];
  logic [31:0] model_a = 32'd0;
  int m_ec = 0;
  int m_tc = 0;

  always #5 clk = ~clk;

  branch_cond_unit #(.DATA_WIDTH(32), .CNT_WIDTH(4), .REG_INPUT(0), .LEGACY_MODE(0)) u_dut0 (
    .clk(clk), .clr(clr), .con_in(con_in), .opa_in(opa_in), .ir_cond(ir_cond),
    .bus_mux_out(bus), .q_ack(q_ack), .cnt_clr(cnt_clr), .q(q0), .q_valid(qv0),
    .busy(busy0), .overrun(ov0), .eval_cnt(ec0), .taken_cnt(tc0));

  branch_cond_unit #(.DATA_WIDTH(32), .CNT_WIDTH(16), .REG_INPUT(1), .LEGACY_MODE(0)) u_dut1 (
    .clk(clk), .clr(clr), .con_in(con_in), .opa_in(opa_in), .ir_cond(ir_cond),
    .bus_mux_out(bus), .q_ack(q_ack), .cnt_clr(cnt_clr), .q(q1), .q_valid(qv1),
    .busy(busy1), .overrun(ov1), .eval_cnt(ec1), .taken_cnt(tc1));

  branch_cond_unit #(.DATA_WIDTH(32), .CNT_WIDTH(16), .REG_INPUT(0), .LEGACY_MODE(1)) u_dut2 (
    .clk(clk), .clr(clr), .con_in(con_in), .opa_in(opa_in), .ir_cond(ir_cond),
    .bus_mux_out(bus), .q_ack(q_ack), .cnt_clr(cnt_clr), .q(q2), .q_valid(qv2),
    .busy(busy2), .overrun(ov2), .eval_cnt(ec2), .taken_cnt(tc2));

  function automatic bit model(input logic [2:0] c, input logic [31:0] b, input logic [31:0] a);
    int sb;
    int sa;
    sb = b;
    sa = a;
    case (c)
      3'd0:    return sb == 0;
      3'd1:    return sb != 0;
      3'd2:    return sb >= 0;
      3'd3:    return sb < 0;
      3'd4:    return sb > 0;
      3'd5:    return sb <= 0;
      3'd6:    return sb == sa;
      default: return sb < sa;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input string tag, input logic obs);
    bit e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=%0b expected=<empty scoreboard>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      chk(tag, {31'd0, obs}, {31'd0, e});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic count_model(input bit r);
    if (m_ec < 15) m_ec++;
    if (r && m_tc < 15) m_tc++;
  endtask

  // One evaluation strobe, predicted result pushed to the scoreboard.
  task automatic eval_step(input logic [2:0] c, input logic [31:0] b, input bit legacy);
    bit r;
    r = model(legacy ? {1'b0, c[1:0]} : c, b, model_a);
    exp_q.push_back(r);
    count_model(r);
    con_in = 1'b1; ir_cond = c; bus = b;
    tick();
    con_in = 1'b0;
  endtask

  task automatic ack();
    q_ack = 1'b1;
    tick();
    q_ack = 1'b0;
  endtask

  task automatic load_opa(input logic [31:0] b);
    opa_in = 1'b1; bus = b;
    tick();
    opa_in = 1'b0;
    model_a = b;
  endtask

  task automatic do_reset();
    clr = 1'b0;
    tick();
    clr = 1'b1;
    model_a = 32'd0; m_ec = 0; m_tc = 0;
    tick();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    bit r;
    tick();
    chk("rst_q", {31'd0, q0}, 32'd0);
    chk("rst_qvalid", {31'd0, qv0}, 32'd0);
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    chk("rst_overrun", {31'd0, ov0}, 32'd0);
    chk("rst_evalcnt", {28'd0, ec0}, 32'd0);
    chk("rst_takencnt", {28'd0, tc0}, 32'd0);
    clr = 1'b1;
    tick();

    eval_step(3'd3, 32'h8000_0000, 1'b0);
    pop_chk("ltz_q", q0);
    chk("ltz_qvalid", {31'd0, qv0}, 32'd1);
    chk("ltz_evalcnt", {28'd0, ec0}, 32'd1);
    chk("ltz_takencnt", {28'd0, tc0}, 32'd1);
    ack();
    chk("ack_qvalid", {31'd0, qv0}, 32'd0);
    chk("ack_q_hold", {31'd0, q0}, 32'd1);

    load_opa(32'd5);
    for (int c = 0; c < 8; c++) begin
      eval_step(3'(c), 32'd5, 1'b0);
      pop_chk($sformatf("mode%0d_q", c), q0);
      ack();
    end
    eval_step(3'd7, 32'hFFFF_FFFD, 1'b0);
    pop_chk("lta_neg_q", q0);
    chk("modes_evalcnt", {28'd0, ec0}, m_ec);
    chk("modes_takencnt", {28'd0, tc0}, m_tc);
    ack();

    // Overrun: strobe in HOLD without ack is dropped.
    eval_step(3'd0, 32'd0, 1'b0);
    pop_chk("pre_ovr_q", q0);
    con_in = 1'b1; ir_cond = 3'd1; bus = 32'd0;
    tick();
    con_in = 1'b0;
    chk("ovr_flag", {31'd0, ov0}, 32'd1);
    chk("ovr_q", {31'd0, q0}, 32'd1);
    chk("ovr_qvalid", {31'd0, qv0}, 32'd1);
    chk("ovr_evalcnt", {28'd0, ec0}, m_ec);

    // Back-to-back: ack and strobe together.
    r = model(3'd1, 32'd0, model_a);
    exp_q.push_back(r);
    count_model(r);
    con_in = 1'b1; q_ack = 1'b1; ir_cond = 3'd1; bus = 32'd0;
    tick();
    con_in = 1'b0; q_ack = 1'b0;
    pop_chk("b2b_q", q0);
    chk("b2b_qvalid", {31'd0, qv0}, 32'd1);
    chk("b2b_evalcnt", {28'd0, ec0}, m_ec);
    chk("ovr_sticky", {31'd0, ov0}, 32'd1);
    ack();

    for (int i = 0; i < 20; i++) begin
      eval_step(3'd0, 32'd0, 1'b0);
      pop_chk("sat_q", q0);
      ack();
    end
    chk("sat_evalcnt", {28'd0, ec0}, 32'd15);
    chk("sat_takencnt", {28'd0, tc0}, 32'd15);

    eval_step(3'd0, 32'd0, 1'b0);
    ack();
    void'(exp_q.pop_front());
    m_ec = 0; m_tc = 0;
    cnt_clr = 1'b1;
    exp_q.push_back(model(3'd0, 32'd0, model_a));
    con_in = 1'b1; ir_cond = 3'd0; bus = 32'd0;
    tick();
    con_in = 1'b0; cnt_clr = 1'b0;
    pop_chk("clr_q", q0);
    chk("clr_evalcnt", {28'd0, ec0}, 32'd0);
    chk("clr_takencnt", {28'd0, tc0}, 32'd0);
    ack();

    // opa_in coincident with con_in: comparison uses the old operand.
    r = model(3'd6, 32'd7, model_a);
    exp_q.push_back(r);
    opa_in = 1'b1; con_in = 1'b1; ir_cond = 3'd6; bus = 32'd7;
    tick();
    opa_in = 1'b0; con_in = 1'b0;
    model_a = 32'd7;
    pop_chk("opa_old_q", q0);
    ack();
    eval_step(3'd6, 32'd7, 1'b0);
    pop_chk("opa_new_q", q0);
    ack();

    // Registered-input build.
    do_reset();
    r = model(3'd4, 32'd1, model_a);
    exp_q.push_back(r);
    con_in = 1'b1; ir_cond = 3'd4; bus = 32'd1;
    tick();
    con_in = 1'b0;
    chk("reg_busy_n1", {31'd0, busy1}, 32'd1);
    chk("reg_qvalid_n1", {31'd0, qv1}, 32'd0);
    tick();
    chk("reg_qvalid_n2", {31'd0, qv1}, 32'd1);
    chk("reg_busy_n2", {31'd0, busy1}, 32'd0);
    pop_chk("reg_q", q1);
    chk("reg_evalcnt", {16'd0, ec1}, 32'd1);
    ack();
    con_in = 1'b1; ir_cond = 3'd0; bus = 32'd0;
    tick();
    con_in = 1'b0;
    chk("reg_busy_eval", {31'd0, busy1}, 32'd1);
    #2 clr = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy1}, 32'd0);
    chk("arst_qvalid", {31'd0, qv1}, 32'd0);
    chk("arst_evalcnt", {16'd0, ec1}, 32'd0);
    @(posedge clk);
    #1 clr = 1'b1;
    model_a = 32'd0;
    tick();
    tick();
    chk("arst_after_qvalid", {31'd0, qv1}, 32'd0);
    chk("arst_after_evalcnt", {16'd0, ec1}, 32'd0);

    // Legacy build: bit 2 of the condition is ignored.
    load_opa(32'd5);
    eval_step(3'd6, 32'd0, 1'b1);
    pop_chk("legacy6_q", q2);
    ack();
    eval_step(3'd7, 32'd0, 1'b1);
    pop_chk("legacy7_q", q2);
    ack();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
